ring_fifo: RTL and testbench
============================

RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 write  input  1  push request; datain captured when accepted.
REQ-006 datain  input  DATA_WIDTH  write data.
REQ-007 read  input  1  pop request for the current head entry.
REQ-008 dataout  output  DATA_WIDTH  head entry (oldest stored word), first-word-fall-through.
REQ-009 val  output  1  high when at least one entry is stored (dataout valid).
REQ-010 full  output  1  high when DEPTH entries are stored.

Function
REQ-011 Storage SHALL be a circular buffer: write pointer, read pointer (log2(DEPTH) bits each) and occupancy count (log2(DEPTH)+1 bits).
REQ-012 A write SHALL be accepted iff write=1 and full=0 at the rising edge; it stores datain at the write pointer and advances the pointer.
REQ-013 A read SHALL be accepted iff read=1 and val=0 is false (val=1) at the rising edge; it advances the read pointer.
REQ-014 Write while full SHALL be dropped, even when a read is accepted in the same cycle; no state changes from it.
REQ-015 Read while empty SHALL be ignored, even when a write is accepted in the same cycle.
REQ-016 Simultaneous accepted read and write SHALL leave count unchanged and move both pointers.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 val and full SHALL be derived from the registered count (val = count!=0, full = count==DEPTH); no combinational path from read/write to val/full.
REQ-019 dataout SHALL be the storage word at the read pointer, combinationally; a word written at edge N is on dataout with val=1 after edge N when FIFO was empty (latency 1 cycle).
REQ-020 After an accepted read at edge N, dataout SHALL present the next oldest word after edge N.
REQ-021 Data order SHALL be strict FIFO; behaviour (val, full, dataout when val=1) SHALL be cycle-identical to the shift-register fifo module of the same parameters.

Reset
REQ-022 While reset=1 at a rising edge: pointers=0, count=0, so val=0, full=0; write/read ignored that cycle.
REQ-023 Storage contents SHALL NOT be reset; dataout is don't-care while val=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries within the same edge.

Configuration
REQ-025 Macro RING_FIFO_ZERO_OUT_EN: when defined, dataout SHALL be forced to all zeros whenever val=0; when undefined, dataout SHALL be the raw storage word at the read pointer.

Structure
REQ-026 Package fifo_pkg SHALL hold default DEPTH/DATA_WIDTH constants and a pointer-width helper (clog2-based) constant function.
REQ-027 One sub-module fifo_mem SHALL implement the DEPTH x DATA_WIDTH storage array (1 write port, 1 async read port); control logic stays in ring_fifo.

Verification
REQ-028 Reset, then write 0xA5 one cycle -> next cycle val=1, dataout=0xA5, full=0.
REQ-029 Write 0x00..0x0F on 16 consecutive cycles, no reads -> full=1 after 16th edge; 17th write 0xFF dropped; then 16 reads return 0x00..0x0F in order, val=0 after last.
REQ-030 Full FIFO, read=1 and write=1 with 0x77 -> read accepted, write dropped, full=0, count 15.
REQ-031 Empty FIFO, read=1 and write=1 with 0x3C -> val=1, dataout=0x3C next cycle, count 1.
REQ-032 Wrap: 10 writes, 10 reads, then 12 writes 0x20..0x2B -> reads return 0x20..0x2B in order, no full.
REQ-033 Random write (50%) and read (50%, never on consecutive cycles) for 50000 cycles alongside the shift-register fifo -> val, full, and dataout (when val=1) match every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the ring_fifo block.
package fifo_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are deliberately left unreset; only the control state in ring_fifo is cleared.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO, first-word-fall-through, registered val/full.
// Optional RING_FIFO_ZERO_OUT_EN forces dataout to zero while empty.
module ring_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  val,
    output logic                  full
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head;

    // Acceptance depends only on registered status, so a full-cycle read never frees room for a same-cycle write.
    assign val    = (count != '0);
    assign full   = (count == FULL_CNT);
    assign wr_acc = write && !full;
    assign rd_acc = read && val;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Writes during reset are suppressed so the reset edge is fully inert.
    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !reset),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (head)
    );

`ifdef RING_FIFO_ZERO_OUT_EN
    assign dataout = val ? head : '0;
`else
    assign dataout = head;
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_ring_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [DW-1:0] datain;
    logic          read;
    logic [DW-1:0] dataout;
    logic          val;
    logic          full;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [DW-1:0] q[$];

    ring_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .datain  (datain),
        .read    (read),
        .dataout (dataout),
        .val     (val),
        .full    (full)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue; acceptance decided from occupancy before the edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            automatic bit do_wr = write && (q.size() < DEPTH);
            automatic bit do_rd = read && (q.size() > 0);
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(datain);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("val_vs_model", 32'(val), 32'(q.size() != 0));
            chk("full_vs_model", 32'(full), 32'(q.size() == DEPTH));
            if (q.size() != 0) chk("dataout_vs_model", 32'(dataout), 32'(q[0]));
        end
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        write  = w;
        datain = d;
        read   = r;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        reset = 1'b0;
    endtask

    task automatic drain_expect(input int n, input logic [DW-1:0] base, input string nm);
        for (int i = 0; i < n; i++) begin
            chk(nm, 32'(dataout), 32'(base + DW'(i)));
            cyc(1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; datain = '0;
        @(posedge clk); #1;
        do_reset();
        chk_en = 1'b1;
        chk("reset_val", 32'(val), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_model_size", 32'(q.size()), 32'd0);

        // Single write, one-cycle fall-through.
        cyc(1'b1, 8'hA5, 1'b0);
        chk("one_val", 32'(val), 32'd1);
        chk("one_dataout", 32'(dataout), 32'hA5);
        chk("one_full", 32'(full), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("one_empty", 32'(val), 32'd0);

        // Fill, overflow drop, ordered drain.
        for (int i = 0; i < 16; i++) begin
            chk("fill_not_full", 32'(full), 32'd0);
            cyc(1'b1, DW'(i), 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 8'hFF, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_head", 32'(dataout), 32'h00);
        chk("ovf_model_size", 32'(q.size()), 32'd16);
        drain_expect(16, 8'h00, "drain_order");
        chk("drain_empty", 32'(val), 32'd0);

        // Full with read+write: read taken, write dropped.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + DW'(i), 1'b0);
        cyc(1'b1, 8'h77, 1'b1);
        chk("rw_full_full", 32'(full), 32'd0);
        chk("rw_full_head", 32'(dataout), 32'h41);
        chk("rw_full_size", 32'(q.size()), 32'd15);
        drain_expect(15, 8'h41, "rw_full_drain");
        chk("rw_full_empty", 32'(val), 32'd0);

        // Empty with read+write: write taken, read ignored.
        cyc(1'b1, 8'h3C, 1'b1);
        chk("rw_empty_val", 32'(val), 32'd1);
        chk("rw_empty_data", 32'(dataout), 32'h3C);
        chk("rw_empty_size", 32'(q.size()), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h90 + DW'(i), 1'b0);
        drain_expect(10, 8'h90, "pre_wrap_drain");
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'h20 + DW'(i), 1'b0);
        chk("wrap_not_full", 32'(full), 32'd0);
        drain_expect(12, 8'h20, "wrap_order");
        chk("wrap_empty", 32'(val), 32'd0);

        // Reset mid-operation discards contents and ignores same-cycle traffic.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + DW'(i), 1'b0);
        do_reset();
        chk("midrst_val", 32'(val), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        cyc(1'b1, 8'h5A, 1'b0);
        chk("post_rst_data", 32'(dataout), 32'h5A);
        cyc(1'b0, 8'h00, 1'b1);

        // Random traffic; reads never on consecutive cycles.
        begin
            logic prev_r = 1'b0;
            for (int n = 0; n < 50000; n++) begin
                logic w, r;
                w = 1'($urandom_range(0, 1));
                r = prev_r ? 1'b0 : 1'($urandom_range(0, 1));
                prev_r = r;
                cyc(w, DW'($urandom), r);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
